// File: rtl/flag_update_unit_pkg.sv
// Shared constants for the flag update unit: opcodes, flag bit positions, FSM states.
package flag_update_unit_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

endpackage

// File: rtl/flag_update_unit_flag_calc.sv
// Combinational flag computation: candidate N/V/Z values plus which of them the opcode updates.
module flag_calc
   import flag_update_unit_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] result,
   input  logic              ovfl,
   output logic [2:0]        flags,
   output logic [2:0]        mask
);

   always_comb begin
      flags         = 3'b000;
      flags[FLAG_N] = result[DATA_W-1];
      flags[FLAG_V] = ovfl;
      flags[FLAG_Z] = (result == '0);
   end

   always_comb begin
      mask = 3'b000;
      case (opcode)
         OP_ADD, OP_SUB:                 mask = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b001;
         default:                        mask = 3'b000;
      endcase
   end

endmodule

// File: rtl/flag_update_unit.sv
// Captures flag updates from the EX stage into a shadow register and commits them
// to the architectural flag register one cycle later.
module flag_update_unit
   import flag_update_unit_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [3:0]        ex_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_ovfl,
   input  logic              pipe_stall,
   input  logic              pipe_flush,
   input  logic              id_is_branch,
   output logic [2:0]        flag_D,
   output logic              flag_WriteReg,
   output logic [2:0]        flags_cur,
   output logic              branch_stall,
   output logic [15:0]       upd_count
);

   logic [2:0]  calc_flags;
   logic [2:0]  calc_mask;
   logic [2:0]  shadow;
   logic [2:0]  merged;
   logic [15:0] count;
   logic        sets_flags;
   logic        capture;
   state_t      state;
   state_t      state_next;

   flag_calc #(.DATA_W(DATA_W)) u_flag_calc (
      .opcode (ex_opcode),
      .result (alu_result),
      .ovfl   (alu_ovfl),
      .flags  (calc_flags),
      .mask   (calc_mask)
   );

   assign sets_flags   = |calc_mask;
   assign capture      = ex_valid & ~pipe_stall & ~pipe_flush & sets_flags;
   assign merged       = (shadow & ~calc_mask) | (calc_flags & calc_mask);
   // A held producer still owes its flags, so pipe_stall does not release the branch.
   assign branch_stall = id_is_branch & ex_valid & ~pipe_flush & sets_flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= 3'b000;
         count  <= 16'h0000;
      end else if (capture) begin
         shadow <= merged;
         count  <= count + 16'h0001;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = ST_IDLE;
      flag_WriteReg = 1'b0;
      if (capture) begin
         state_next = ST_COMMIT;
      end
      if (state == ST_COMMIT) begin
         flag_WriteReg = 1'b1;
      end
   end

   assign flag_D    = shadow;
   assign flags_cur = shadow;
   assign upd_count = count;

endmodule

// File: tb/tb_flag_update_unit.sv
// Self-checking bench for flag_update_unit: directed scenarios plus randomized traffic
// compared against a behavioural flag model.
module tb_flag_update_unit;

   localparam int DATA_W = 16;

   logic              clk;
   logic              rst;
   logic              ex_valid;
   logic [3:0]        ex_opcode;
   logic [DATA_W-1:0] alu_result;
   logic              alu_ovfl;
   logic              pipe_stall;
   logic              pipe_flush;
   logic              id_is_branch;
   logic [2:0]        flag_D;
   logic              flag_WriteReg;
   logic [2:0]        flags_cur;
   logic              branch_stall;
   logic [15:0]       upd_count;

   int checks = 0;
   int errors = 0;

   logic [2:0]  exp_flags = 3'b000;
   logic        exp_wr    = 1'b0;
   int          exp_cnt   = 0;

   flag_update_unit #(.DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_opcode     (ex_opcode),
      .alu_result    (alu_result),
      .alu_ovfl      (alu_ovfl),
      .pipe_stall    (pipe_stall),
      .pipe_flush    (pipe_flush),
      .id_is_branch  (id_is_branch),
      .flag_D        (flag_D),
      .flag_WriteReg (flag_WriteReg),
      .flags_cur     (flags_cur),
      .branch_stall  (branch_stall),
      .upd_count     (upd_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 2 = updates N,V,Z; 1 = updates Z only; 0 = no flag effect
   function automatic int opClass(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return 2;
      if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 1;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      check("flags_cur", {13'd0, flags_cur}, {13'd0, exp_flags});
      check("flag_D", {13'd0, flag_D}, {13'd0, exp_flags});
      check("flag_WriteReg", {15'd0, flag_WriteReg}, {15'd0, exp_wr});
      check("upd_count", upd_count, exp_cnt[15:0]);
   endtask

   // Drive one cycle of inputs, check the combinational stall, clock, then check registered state.
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] op,
                                input logic [15:0] res, input logic ov, input logic st,
                                input logic fl, input logic br, input logic doCheck);
      int  cls;
      bit  cap;
      logic n, vv, z;
      rst          = r;
      ex_valid     = v;
      ex_opcode    = op;
      alu_result   = res;
      alu_ovfl     = ov;
      pipe_stall   = st;
      pipe_flush   = fl;
      id_is_branch = br;
      #1;
      cls = opClass(op);
      if (doCheck)
         check("branch_stall", {15'd0, branch_stall}, {15'd0, (br && v && !fl && cls != 0)});
      cap = v && !st && !fl && cls != 0;
      n  = res[15];
      vv = ov;
      z  = (res == 16'd0);
      @(posedge clk);
      #1;
      if (r) begin
         exp_flags = 3'b000;
         exp_cnt   = 0;
         exp_wr    = 1'b0;
      end else begin
         exp_wr = cap;
         if (cap) begin
            exp_cnt = (exp_cnt + 1) % 65536;
            if (cls == 2) exp_flags = {n, vv, z};
            else          exp_flags = {exp_flags[2], exp_flags[1], z};
         end
      end
      if (doCheck) checkOutput();
   endtask

   initial begin
      rst = 1'b1; ex_valid = 0; ex_opcode = 0; alu_result = 0; alu_ovfl = 0;
      pipe_stall = 0; pipe_flush = 0; id_is_branch = 0;

      applyStimulus(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1);
      check("reset_flag_D", {13'd0, flag_D}, 16'h0000);

      // ADD zero with overflow
      applyStimulus(0, 1, 4'h0, 16'h0000, 1, 0, 0, 0, 1);
      check("add_zero_flags", {13'd0, flag_D}, 16'h0003);
      check("add_zero_count", upd_count, 16'h0001);

      // SUB negative then XOR zero keeps N
      applyStimulus(0, 1, 4'h1, 16'h8000, 0, 0, 0, 0, 1);
      check("sub_neg_flags", {13'd0, flag_D}, 16'h0004);
      applyStimulus(0, 1, 4'h2, 16'h0000, 1, 0, 0, 0, 1);
      check("xor_zero_flags", {13'd0, flag_D}, 16'h0005);

      // Flushed and stalled ADDs do nothing
      applyStimulus(0, 1, 4'h0, 16'h0001, 0, 0, 1, 0, 1);
      applyStimulus(0, 1, 4'h0, 16'h0001, 0, 1, 0, 0, 1);
      check("stall_no_write", {15'd0, flag_WriteReg}, 16'h0000);
      check("stall_flags_kept", {13'd0, flags_cur}, 16'h0005);

      // Branch stall with SUB (stalled too) and with LW
      applyStimulus(0, 1, 4'h1, 16'h0010, 0, 1, 0, 1, 1);
      applyStimulus(0, 1, 4'h8, 16'h0000, 0, 0, 0, 1, 1);
      applyStimulus(0, 1, 4'h1, 16'h0010, 0, 0, 1, 1, 1);

      // Three back-to-back ADDs
      applyStimulus(0, 1, 4'h0, 16'h0001, 0, 0, 0, 0, 1);
      check("b2b_1", {13'd0, flag_D}, 16'h0000);
      applyStimulus(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 1);
      check("b2b_2", {13'd0, flag_D}, 16'h0001);
      applyStimulus(0, 1, 4'h0, 16'hFFFF, 0, 0, 0, 0, 1);
      check("b2b_3", {13'd0, flag_D}, 16'h0004);
      check("b2b_wr", {15'd0, flag_WriteReg}, 16'h0001);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                       4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                       1'($urandom), 1);
      end

      // Reset beats a simultaneous capture, including one pending in COMMIT
      applyStimulus(0, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 1);
      applyStimulus(1, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 1);
      check("rst_cap_flags", {13'd0, flags_cur}, 16'h0000);
      check("rst_cap_wr", {15'd0, flag_WriteReg}, 16'h0000);

      // Drive the counter to 0xFFFF, then wrap it
      for (int i = 0; i < 65535; i++) begin
         applyStimulus(0, 1, 4'h6, 16'(i), 0, 0, 0, 0, (i % 1024 == 0));
      end
      checkOutput();
      check("count_full", upd_count, 16'hFFFF);
      applyStimulus(0, 1, 4'h0, 16'h1234, 0, 0, 0, 0, 1);
      check("count_wrap", upd_count, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
